// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe. The tri-state result bus
// stays a plain port on the block so its high-Z drive is resolved at the net.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;

  modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid);
  modport slave  (input in_valid, op, a, b, out_ready, output in_ready, out_valid);
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with a tri-state result bus and a
// saturating completed-operation counter.
module logic_unit_lane (
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       res,
  output logic       en
);
  always_comb begin
    res = 1'b0;
    en  = 1'b1;
    case (op)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: res = ~a;
      3'd3: res = ~(a & b);
      3'd4: res = ~(a | b);
      3'd5: res = a ^ b;
      3'd6: res = ~(a ^ b);
      3'd7: begin
        res = a;
        en  = b;
      end
      default: res = 1'b0;
    endcase
  end
endmodule

module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_unit_pipe_if.slave bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] op_count,
  output wire  [WIDTH-1:0] o
);
  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] drv;
  } rsp_t;

  logic [2:1]       vld_pipe;
  req_t             s1_q;
  rsp_t             s2_q;
  logic [WIDTH-1:0] lane_res;
  logic [WIDTH-1:0] lane_drv;
  logic             out_hs, in_hs, s1_adv, s2_adv;

  assign out_hs        = vld_pipe[2] & bus.out_ready;
  assign s2_adv        = ~vld_pipe[2] | out_hs;
  assign s1_adv        = ~vld_pipe[1] | s2_adv;
  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = vld_pipe[2];
  assign in_hs         = bus.in_valid & s1_adv;

  // Stage data only loads on a real transfer so a held stage never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= bus.in_valid;
      if (in_hs)  s1_q <= '{op: bus.op, a: bus.a, b: bus.b};
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= '{res: lane_res, drv: lane_drv};
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic_unit_lane u_lane (
      .op  (s1_q.op),
      .a   (s1_q.a[i]),
      .b   (s1_q.b[i]),
      .res (lane_res[i]),
      .en  (lane_drv[i])
    );
    assign o[i] = (vld_pipe[2] && s2_q.drv[i]) ? s2_q.res[i] : 1'bz;
  end

  // Clear wins over a simultaneous handshake; count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          op_count <= '0;
    else if (clr_cnt)                    op_count <= '0;
    else if (out_hs && (op_count != '1)) op_count <= op_count + CNT_W'(1);
  end
endmodule
